// File: rtl/peripheral_7seg_scan.sv
// peripheral_7seg_scan
//   Time-multiplexed driver for a multi-digit 7-segment display.
//
//   A load strobe copies the value, mode, blink mask and decimal points into
//   shadow registers. A prescaler divides clk into digit slots, and each slot
//   enables one anode. The decoded segments are registered, so the outputs
//   follow idx and the shadow registers one cycle later. In the first cycle of
//   every slot all anodes are off so that the previous digit does not ghost
//   onto the next one.
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous, active-high reset
//     load        capture value/mode/blink_mask/dp_in
//     value       packed digits, digit i = value[4*i+3:4*i]
//     mode        00 hex, 01 hex with leading-zero blank, 10 glyph, 11 blank
//     blink_mask  per-digit blink enable
//     dp_in       per-digit decimal point
//     an          digit enables, an[i] drives digit i
//     seg         segments {g,f,e,d,c,b,a}
//     dp          decimal point
//     scan_tick   one-cycle pulse at each digit-slot boundary
module peripheral_7seg_scan #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int BLINK_SCANS    = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [1:0]              mode,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    scan_tick
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(BLINK_SCANS - 1);

  // Internal output registers are active low; INV flips them for active-high boards.
  localparam logic INV = SEG_ACTIVE_LOW ? 1'b0 : 1'b1;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [1:0]              sh_mode;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic [NUM_DIGITS-1:0]   sh_dp;

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [SW-1:0]           scan_cnt;
  logic                    blink_phase;

  logic [NUM_DIGITS-1:0]   an_l;
  logic [6:0]              seg_l;
  logic                    dp_l;
  logic                    tick_q;

  logic                    slot_end;
  logic [3:0]              digit;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;
  logic [6:0]              seg_dec;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] code);
    case (code)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h18;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  // Glyph set: A, b, r and a dash. Every other code stays dark.
  function automatic logic [6:0] glyph_seg(input logic [3:0] code);
    case (code)
      4'hA:    glyph_seg = 7'h08;
      4'hB:    glyph_seg = 7'h03;
      4'hC:    glyph_seg = 7'h2F;
      4'hF:    glyph_seg = 7'h3F;
      default: glyph_seg = 7'h7F;
    endcase
  endfunction

  assign slot_end = (pre == PRE_LAST);
  assign digit    = sh_value[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every higher digit are zero.
  // Digit 0 always shows, so a value of 0 still displays "0".
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (sh_value[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_run && (i != 0);
    end
  end

  always_comb begin
    seg_dec = hex_seg(digit);
    blank   = 1'b0;
    case (sh_mode)
      2'b00: blank = 1'b0;
      2'b01: blank = lz_blank[idx];
      2'b10: seg_dec = glyph_seg(digit);
      default: blank = 1'b1;
    endcase
    if (sh_blink[idx] && blink_phase) blank = 1'b1;

    seg_next = blank ? 7'h7F : seg_dec;
    dp_next  = blank ? 1'b1 : ~sh_dp[idx];

    // All anodes are turned off on the edge where the slot changes. In that cycle
    // the registered prescaler reads 0, and seg still holds the previous digit.
    an_next = '1;
    if (!slot_end) an_next[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_value    <= '0;
      sh_mode     <= 2'b11;
      sh_blink    <= '0;
      sh_dp       <= '0;
      pre         <= '0;
      idx         <= '0;
      scan_cnt    <= '0;
      blink_phase <= 1'b0;
      an_l        <= '1;
      seg_l       <= 7'h7F;
      dp_l        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_mode  <= mode;
        sh_blink <= blink_mask;
        sh_dp    <= dp_in;
      end

      if (slot_end) begin
        pre <= '0;
        if (idx == IDX_LAST) begin
          idx <= '0;
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt    <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            scan_cnt <= scan_cnt + SW'(1);
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        pre <= pre + PW'(1);
      end

      tick_q <= slot_end;
      an_l   <= an_next;
      seg_l  <= seg_next;
      dp_l   <= dp_next;
    end
  end

  assign an        = an_l ^ {NUM_DIGITS{INV}};
  assign seg       = seg_l ^ {7{INV}};
  assign dp        = dp_l ^ INV;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_peripheral_7seg_scan.sv
module tb_peripheral_7seg_scan;

  localparam int N  = 4;
  localparam int CD = 4;
  localparam int BS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [4*N-1:0] value;
  logic [1:0]    mode;
  logic [N-1:0]  blink_mask;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          scan_tick;

  always #5 clk = ~clk;

  peripheral_7seg_scan #(
    .NUM_DIGITS(N), .CLK_DIV(CD), .BLINK_SCANS(BS), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .mode(mode),
    .blink_mask(blink_mask), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // The reference model counts the edges since reset. The slot, digit and blink
  // phase are all computed from that count with plain arithmetic.
  int unsigned k;
  logic [4*N-1:0] m_val;
  logic [1:0]     m_mode;
  logic [N-1:0]   m_blink;
  logic [N-1:0]   m_dp;

  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns {dp, seg} for digit i at edge count kk, active low.
  function automatic logic [7:0] ref_digit(input int i, input int unsigned kk);
    logic [3:0] code;
    logic [6:0] s;
    bit         blank;
    code  = 4'((m_val >> (4*i)) & 16'hF);
    s     = HEX[code];
    blank = 0;
    case (m_mode)
      2'd1: if (i > 0 && (m_val >> (4*i)) == 0) blank = 1;
      2'd2: begin
        case (code)
          4'hA: s = 7'h08;
          4'hB: s = 7'h03;
          4'hC: s = 7'h2F;
          4'hF: s = 7'h3F;
          default: s = 7'h7F;
        endcase
      end
      2'd3: blank = 1;
      default: ;
    endcase
    if (m_blink[i] && (((kk / (CD*N)) / BS) % 2 == 1)) blank = 1;
    return blank ? {1'b1, 7'h7F} : {~m_dp[i], s};
  endfunction

  // One clock edge: the model advances using the inputs present at the edge,
  // then the outputs are compared 1 ns after the edge.
  task automatic edge_step();
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp, e_tick;
    logic [7:0]   r;
    int           i;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      k = 0; m_val = '0; m_mode = 2'b11; m_blink = '0; m_dp = '0;
    end else begin
      i      = int'((k / CD) % N);
      r      = ref_digit(i, k);
      e_tick = (k % CD == CD - 1);
      e_an   = e_tick ? {N{1'b1}} : ~(N'(1) << i);
      e_seg  = r[6:0];
      e_dp   = r[7];
      if (load) begin
        m_val = value; m_mode = mode; m_blink = blink_mask; m_dp = dp_in;
      end
      k++;
    end
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("scan_tick", 32'(scan_tick), 32'(e_tick));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [1:0] m,
                         input logic [N-1:0] b, input logic [N-1:0] d, input int hold);
    load = 1'b1; value = v; mode = m; blink_mask = b; dp_in = d;
    edge_step();
    load = 1'b0;
    repeat (hold) edge_step();
  endtask

  initial begin
    int guard;
    reset = 1'b1; load = 1'b0; value = '0; mode = '0; blink_mask = '0; dp_in = '0;
    k = 0; m_val = '0; m_mode = 2'b11; m_blink = '0; m_dp = '0;

    repeat (10) begin
      edge_step();
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
    end
    reset = 1'b0;
    repeat (8) edge_step();

    do_load(16'h12AF, 2'b00, 4'b0000, 4'b0000, 40);
    do_load(16'h0050, 2'b01, 4'b0000, 4'b0000, 20);
    do_load(16'h0000, 2'b01, 4'b0000, 4'b0000, 20);
    do_load(16'hABCF, 2'b10, 4'b0000, 4'b0000, 20);
    do_load(16'h5555, 2'b10, 4'b0000, 4'b0000, 20);
    do_load(16'h1234, 2'b00, 4'b0001, 4'b0001, 140);

    // Reset in the middle of the slot for digit 2. The load in the same cycle must be ignored.
    guard = 0;
    while (!(((k / CD) % N) == 2 && (k % CD) == 1) && guard < 64) begin
      edge_step();
      guard++;
    end
    check("reach_idx2", 32'(guard < 64), 32'd1);
    reset = 1'b1; load = 1'b1; value = 16'hFFFF; mode = 2'b00; dp_in = '1; blink_mask = '0;
    edge_step();
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    reset = 1'b0; load = 1'b0;
    repeat (24) edge_step();

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      load  = ($urandom_range(0, 24) == 0);
      for (int d = 0; d < N; d++)
        value[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      mode       = 2'($urandom_range(0, 3));
      blink_mask = N'($urandom);
      dp_in      = N'($urandom);
      edge_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
